// File: rtl/user_core_mux_wrapper.sv
// Multi-core user-area top: Wishbone register bank plus a guarded GPIO mux that drains pads before a core switch.
// Optional feature macro: USER_MUX_IRQ_EN (one-cycle user_irq[0] pulse on switch completion).
module user_core_mux_wrapper #(
    parameter int          NUM_CORES     = 2,
    parameter int          IO_W          = 38,
    parameter logic [31:0] BASE_ADR      = 32'h3000_0000,
    parameter logic [7:0]  GUARD_DEFAULT = 8'd4,
    parameter logic [31:0] CORE_ID       = 32'h534F_4E02
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic [31:0]               wbs_dat_o,
    output logic                      wbs_ack_o,
    input  logic [NUM_CORES*IO_W-1:0] core_io_out,
    input  logic [NUM_CORES*IO_W-1:0] core_io_oeb,
    output logic [NUM_CORES-1:0]      core_rst_no,
    output logic [IO_W-1:0]           io_out,
    output logic [IO_W-1:0]           io_oeb,
    output logic [2:0]                user_irq
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [7:0] NC8 = 8'(NUM_CORES);

    state_t      state_r, state_nxt_s;
    logic [7:0]  cnt_r, cur_r, req_r, guard_r;
    logic        done_r, err_r, ack_r;
    logic [31:0] dat_r, rdata_s;
    logic        hit_s, acc_s, wr_s, rd_s, ctrl_wr_s, status_wr_s, guard_wr_s, busy_s;
    logic        start_s, err_set_s;
    logic [7:0]  start_req_s;
    logic        unused_s;

    assign hit_s       = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign acc_s       = wbs_cyc_i & wbs_stb_i & ~ack_r & hit_s;
    assign wr_s        = acc_s & wbs_we_i;
    assign rd_s        = acc_s & ~wbs_we_i;
    assign ctrl_wr_s   = wr_s & (wbs_adr_i[3:2] == 2'd0);
    assign status_wr_s = wr_s & (wbs_adr_i[3:2] == 2'd1);
    assign guard_wr_s  = wr_s & (wbs_adr_i[3:2] == 2'd2) & wbs_sel_i[0];
    assign busy_s      = (state_r != ST_ACTIVE);
    assign unused_s    = ^{wbs_adr_i[1:0], wbs_dat_i[30:11], wbs_dat_i[8], wbs_sel_i[2]};

    // Decode a CTRL write into switch start, target select or error
    always_comb begin
        start_s     = 1'b0;
        start_req_s = cur_r;
        err_set_s   = 1'b0;
        if (ctrl_wr_s) begin
            if (busy_s) begin
                err_set_s = 1'b1;
            end else if (wbs_sel_i[3] && wbs_dat_i[31]) begin
                start_s = 1'b1;   // soft reset: drain and re-release the same core
            end else if (wbs_sel_i[0]) begin
                if (wbs_dat_i[7:0] >= NC8) begin
                    err_set_s = 1'b1;
                end else if (wbs_dat_i[7:0] != cur_r) begin
                    start_s     = 1'b1;
                    start_req_s = wbs_dat_i[7:0];
                end else begin
                    start_s = 1'b0;
                end
            end else begin
                start_s = 1'b0;
            end
        end else begin
            start_s = 1'b0;
        end
    end

    // Switch sequencer state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_r <= ST_DRAIN;
        else            state_r <= state_nxt_s;
    end

    // Switch sequencer next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ACTIVE: state_nxt_s = start_s ? ST_DRAIN : ST_ACTIVE;
            ST_DRAIN:  state_nxt_s = (cnt_r == 8'd0) ? ST_SWITCH : ST_DRAIN;
            ST_SWITCH: state_nxt_s = ST_ACTIVE;
            default:   state_nxt_s = ST_DRAIN;
        endcase
    end

    // Register bank, drain counter and Wishbone response
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_r   <= GUARD_DEFAULT;
            cur_r   <= 8'd0;
            req_r   <= 8'd0;
            guard_r <= GUARD_DEFAULT;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            ack_r   <= 1'b0;
            dat_r   <= 32'd0;
        end else begin
            ack_r <= acc_s;
            dat_r <= rd_s ? rdata_s : 32'd0;
            if (start_s) begin
                cnt_r <= guard_r;
                req_r <= start_req_s;
            end else if (state_r == ST_DRAIN && cnt_r != 8'd0) begin
                cnt_r <= cnt_r - 8'd1;
            end
            if (state_r == ST_SWITCH) cur_r <= req_r;
            if (guard_wr_s) guard_r <= wbs_dat_i[7:0];
            // A completing switch outranks a simultaneous W1C of done
            if (state_r == ST_SWITCH)                                 done_r <= 1'b1;
            else if (status_wr_s && wbs_sel_i[1] && wbs_dat_i[9])     done_r <= 1'b0;
            if (err_set_s)                                            err_r  <= 1'b1;
            else if (status_wr_s && wbs_sel_i[1] && wbs_dat_i[10])    err_r  <= 1'b0;
        end
    end

    // Read-data mux
    always_comb begin
        rdata_s = 32'd0;
        case (wbs_adr_i[3:2])
            2'd0:    rdata_s = {24'd0, req_r};
            2'd1:    rdata_s = {21'd0, err_r, done_r, busy_s, cur_r};
            2'd2:    rdata_s = {24'd0, guard_r};
            2'd3:    rdata_s = CORE_ID;
            default: rdata_s = 32'd0;
        endcase
    end

    // Pad mux: only the active core reaches the pads and leaves reset
    always_comb begin
        io_out      = {IO_W{1'b0}};
        io_oeb      = {IO_W{1'b1}};
        core_rst_no = {NUM_CORES{1'b0}};
        if (state_r == ST_ACTIVE) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (cur_r == 8'(k)) begin
                    io_out         = core_io_out[k*IO_W +: IO_W];
                    io_oeb         = core_io_oeb[k*IO_W +: IO_W];
                    core_rst_no[k] = 1'b1;
                end else begin
                    core_rst_no[k] = 1'b0;
                end
            end
        end else begin
            core_rst_no = {NUM_CORES{1'b0}};
        end
    end

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;

`ifdef USER_MUX_IRQ_EN
    logic irq_r;

    // Completion pulse in the first cycle after SWITCH
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) irq_r <= 1'b0;
        else            irq_r <= (state_r == ST_SWITCH);
    end

    assign user_irq = {2'b00, irq_r};
`else
    assign user_irq = 3'b000;
`endif

endmodule
